pipe_flow_ctl: RTL and testbench

- Flow-control stage wrapped around the fixed-latency, stall-free arithmetic pipe.
- The arithmetic pipe computes s2 = (x+y)^2 and out = x*x - 1 with a 3-cycle latency. It has no valid signal and no reset.
- Upstream side: this block accepts x/y under a valid/ready handshake, drives the pipe inputs and tracks in-flight tokens.
- Downstream side: it captures the pipe results into a small FIFO and presents them under valid/ready. Credit accounting guarantees no result is ever dropped, because the pipe itself cannot stall.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_flow_ctl_if.sv | 27 ++
 rtl/pipe_res_fifo.sv | 59 +++++
 rtl/pipe_flow_ctl.sv | 87 ++++++++
 tb/tb_pipe_flow_ctl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, width helpers and result type for the pipe flow stage
package pipe_pkg;

    localparam int PIPE_LAT = 3;
    localparam int PIPE_W   = 8;

    function automatic int S2_W(input int w);
        return 2 * w + 2;
    endfunction

    function automatic int D_W(input int w);
        return 2 * w;
    endfunction

    typedef struct packed {
        logic [S2_W(PIPE_W)-1:0] s2;
        logic [D_W(PIPE_W)-1:0]  d;
    } pipe_res_t;

endpackage

// File: rtl/pipe_flow_ctl_if.sv
// rtl/pipe_flow_ctl_if.sv - upstream operand and downstream result handshakes
interface pipe_flow_ctl_if
    import pipe_pkg::*;
#(
    parameter int W = 8
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_x;
    logic [W-1:0]         in_y;
    logic                 out_valid;
    logic                 out_ready;
    logic [S2_W(W)-1:0]   out_s2;
    logic [D_W(W)-1:0]    out_d;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_s2, out_d
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_s2, out_d
    );

endinterface

// File: rtl/pipe_res_fifo.sv
// rtl/pipe_res_fifo.sv - registered result FIFO with flush and drop-on-full reporting
module pipe_res_fifo #(
    parameter int DW    = 34,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          drop
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign drop    = push & full;
    // Head reads as zero while empty so stale storage never shows on the outputs.
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pipe_flow_ctl.sv
// rtl/pipe_flow_ctl.sv - credit-based valid/ready wrapper around a fixed-latency stall-free pipe
module pipe_flow_ctl
    import pipe_pkg::*;
#(
    parameter int W     = 8,
    parameter int LAT   = PIPE_LAT,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    pipe_flow_ctl_if.slave       bus,
    output logic [W-1:0]         pipe_x,
    output logic [W-1:0]         pipe_y,
    input  logic [S2_W(W)-1:0]   pipe_s2,
    input  logic [D_W(W)-1:0]    pipe_out,
    output logic                 ovf_err
);

    localparam int S2W = S2_W(W);
    localparam int DDW = D_W(W);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int IW  = $clog2(LAT + 1);
    localparam int CRW = $clog2(DEPTH + LAT + 1) + 1;

    logic [LAT-1:0]     vld_sr;
    logic [IW-1:0]      inflight;
    logic [CW-1:0]      fifo_count;
    logic [CRW-1:0]     credit;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_drop;
    logic               acc;
    logic               push;
    logic               pop;
    logic [S2W+DDW-1:0] head;

    assign pipe_x = bus.in_x;
    assign pipe_y = bus.in_y;

    // Credit counts both stored results and tokens still inside the pipe, from registered state only.
    assign inflight     = IW'($countones(vld_sr));
    assign credit       = CRW'(fifo_count) + CRW'(inflight);
    assign bus.in_ready = ~flush & ~fifo_full & (credit < CRW'(DEPTH));
    assign acc          = bus.in_valid & bus.in_ready;
    assign push         = vld_sr[LAT-1];
    assign pop          = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else if (flush) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[LAT-2:0], acc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
        end else if (fifo_drop) begin
            ovf_err <= 1'b1;
        end
    end

    pipe_res_fifo #(
        .DW    (S2W + DDW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data ({pipe_s2, pipe_out}),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign bus.out_valid          = ~fifo_empty;
    assign {bus.out_s2, bus.out_d} = head;

endmodule

// File: tb/tb_pipe_flow_ctl.sv
// tb/tb_pipe_flow_ctl.sv - randomized and directed self-checking bench for pipe_flow_ctl
module tb_pipe_flow_ctl;
    import pipe_pkg::*;

    localparam int W     = 8;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [7:0]  pipe_x;
    logic [7:0]  pipe_y;
    logic [17:0] pipe_s2;
    logic [15:0] pipe_out;
    logic        ovf_err;

    int checks   = 0;
    int failures = 0;

    pipe_flow_ctl_if #(.W(W)) bus ();

    pipe_flow_ctl #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .pipe_x   (pipe_x),
        .pipe_y   (pipe_y),
        .pipe_s2  (pipe_s2),
        .pipe_out (pipe_out),
        .ovf_err  (ovf_err)
    );

    always #5 clk = ~clk;

    // Arithmetic pipe: three register stages, no valid, no reset.
    logic [17:0] sum18;
    logic [15:0] x16;
    logic [17:0] ps2 [3];
    logic [15:0] pd  [3];
    always_comb begin
        sum18 = {10'd0, pipe_x} + {10'd0, pipe_y};
        x16   = {8'd0, pipe_x};
    end
    always_ff @(posedge clk) begin
        ps2[0] <= sum18 * sum18;
        pd[0]  <= x16 * x16 - 16'd1;
        ps2[1] <= ps2[0];
        pd[1]  <= pd[0];
        ps2[2] <= ps2[1];
        pd[2]  <= pd[1];
    end
    assign pipe_s2  = ps2[2];
    assign pipe_out = pd[2];

    function automatic pipe_res_t calc(input logic [7:0] x, input logic [7:0] y);
        int s;
        pipe_res_t r;
        s    = int'(x) + int'(y);
        r.s2 = 18'(s * s);
        r.d  = 16'(int'(x) * int'(x) - 1);
        return r;
    endfunction

    function automatic pipe_res_t mkr(input int s2, input int d);
        pipe_res_t r;
        r.s2 = 18'(s2);
        r.d  = 16'(d);
        return r;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference model: tokens waiting in the pipe with their arrival cycle, then a result queue.
    pipe_res_t fly_q[$];
    int        fly_due[$];
    pipe_res_t fifo_q[$];
    pipe_res_t em_q[$];
    int        cyc = 0;

    function automatic bit m_ready();
        return !flush && ((fifo_q.size() + fly_q.size()) < DEPTH);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit acc;
        bit pop;
        if (!rst_n) begin
            fly_q.delete();
            fly_due.delete();
            fifo_q.delete();
        end else begin
            cyc++;
            acc = bus.in_valid && m_ready();
            pop = (fifo_q.size() != 0) && bus.out_ready;
            if (flush) begin
                fly_q.delete();
                fly_due.delete();
                fifo_q.delete();
            end else begin
                if (pop) void'(fifo_q.pop_front());
                if (fly_q.size() != 0 && fly_due[0] == cyc) begin
                    fifo_q.push_back(fly_q.pop_front());
                    void'(fly_due.pop_front());
                end
                if (acc) begin
                    fly_q.push_back(calc(bus.in_x, bus.in_y));
                    fly_due.push_back(cyc + LAT);
                end
            end
        end
    end

    always @(negedge clk) begin
        pipe_res_t h;
        bit        ev;
        ev = (fifo_q.size() != 0);
        h  = ev ? fifo_q[0] : '0;
        chk("in_ready", bus.in_ready, m_ready());
        chk("out_valid", bus.out_valid, ev);
        chk("out_s2", bus.out_s2, h.s2);
        chk("out_d", bus.out_d, h.d);
        chk("ovf_err", ovf_err, 0);
        if (bus.out_valid && bus.out_ready) em_q.push_back({bus.out_s2, bus.out_d});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_em(input string nm, input pipe_res_t exp_q[$]);
        chk({nm, "_count"}, em_q.size(), exp_q.size());
        for (int i = 0; i < em_q.size() && i < exp_q.size(); i++) begin
            chk({nm, "_s2"}, em_q[i].s2, exp_q[i].s2);
            chk({nm, "_d"}, em_q[i].d, exp_q[i].d);
        end
    endtask

    initial begin
        pipe_res_t ex_q[$];
        bit        took;
        int        nx;
        int        acc_n;
        int        sent;

        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        // Single operand: result visible exactly four cycles after acceptance.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_x      = 8'd3;
        bus.in_y      = 8'd4;
        step();
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("t1_valid", bus.out_valid, (k == 4));
            chk("t1_in_ready", bus.in_ready, 1);
            if (k == 4) begin
                chk("t1_s2", bus.out_s2, 49);
                chk("t1_d", bus.out_d, 8);
            end
        end

        // Extremes back-to-back, including the d wrap.
        step();
        em_q.delete();
        bus.in_valid = 1'b1;
        bus.in_x = 8'd0;
        bus.in_y = 8'd0;
        step();
        bus.in_x = 8'd255;
        bus.in_y = 8'd255;
        step();
        bus.in_valid = 1'b0;
        repeat (8) step();
        ex_q = {};
        ex_q.push_back(mkr(0, 16'hFFFF));
        ex_q.push_back(mkr(260100, 65024));
        chk_em("t2", ex_q);

        // Back-pressure: credits cap acceptance at DEPTH.
        em_q.delete();
        bus.out_ready = 1'b0;
        nx = 1;
        acc_n = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 12) begin
                chk("t3_accepted", acc_n, 4);
                chk("t3_in_ready", bus.in_ready, 0);
                chk("t3_ovf", ovf_err, 0);
                bus.out_ready = 1'b1;
            end
            bus.in_valid = (nx <= 6);
            bus.in_x     = 8'(nx);
            bus.in_y     = 8'd0;
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            step();
            if (took) begin
                nx++;
                acc_n++;
            end
        end
        bus.in_valid = 1'b0;
        ex_q = {};
        for (int i = 1; i <= 6; i++) ex_q.push_back(mkr(i * i, i * i - 1));
        chk_em("t3", ex_q);

        // Streaming with random operands.
        em_q.delete();
        ex_q = {};
        bus.out_ready = 1'b1;
        sent = 0;
        for (int c = 0; c < 60; c++) begin
            bus.in_valid = (sent < 20);
            bus.in_x     = 8'($urandom_range(0, 255));
            bus.in_y     = 8'($urandom_range(0, 255));
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            if (took) ex_q.push_back(calc(bus.in_x, bus.in_y));
            step();
            if (took) sent++;
        end
        bus.in_valid = 1'b0;
        chk("t4_sent", sent, 20);
        chk_em("t4", ex_q);

        // Flush with two results stored and two in flight.
        step();
        em_q.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = 8'(10 + i);
            bus.in_y     = 8'(i);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("t5_ready_in_flush", bus.in_ready, 0);
        chk("t5_valid_pre", bus.out_valid, 1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("t5_valid_post", bus.out_valid, 0);
        chk("t5_ready_post", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        repeat (10) step();
        chk("t5_no_results", em_q.size(), 0);

        // Reset mid-stream with three tokens in the pipe.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = 8'($urandom_range(1, 255));
            bus.in_y     = 8'($urandom_range(1, 255));
            step();
        end
        chk("t6_ready_pre", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        em_q.delete();
        @(negedge clk);
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_ready", bus.in_ready, 1);
        chk("t6_s2", bus.out_s2, 0);
        chk("t6_d", bus.out_d, 0);
        chk("t6_ovf", ovf_err, 0);
        step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("t6_no_stale", em_q.size(), 0);

        // Random traffic with occasional flushes.
        for (int c = 0; c < 600; c++) begin
            flush         = ($urandom_range(0, 29) == 0);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.in_x      = 8'($urandom_range(0, 255));
            bus.in_y      = 8'($urandom_range(0, 255));
            step();
        end
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) step();
        chk("final_empty", bus.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
